mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the MIPS execute stage, sitting beside the ALU. It takes the same register-file operands the ALU receives and holds its results in the architectural HI/LO registers. MFHI/MFLO read data goes to the writeback result mux alongside the ALU output. Multi-cycle operations stall the core through a busy/stall handshake.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the iteration counter is sized from it.

Ports:
- clk_i  in  1  core clock; all state changes on the rising edge
- reset_n_i  in  1  synchronous, active-low reset
- start_i  in  1  instruction valid at the MDU this cycle
- funct_i6  in  6  R-type funct field: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
- a_i32  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
- b_i32  in  32  rt operand (divisor / multiplier)
- y_o32  out  32  combinational read data: HI on MFHI, LO on MFLO, else 0
- busy_o  out  1  high while a MULT/DIV is in flight
- stall_o  out  1  combinational; high when start_i is high with any MDU funct while busy_o is high
- done_o  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result
- illegal_o  out  1  one-cycle pulse for an unsupported funct (see Configuration)

## Operation
- States:
  - IDLE: accepts instructions.
  - CALC: 32 iterations; count runs 31 to 0.
  - FIX: sign correction and HI/LO write.
- Instructions act only when start_i=1 and funct_i6 is an MDU funct. All other functs are ignored.
- MTHI/MTLO in IDLE: HI or LO takes a_i32 at the next edge.
- MFHI/MFLO: y_o32 is combinational from the current HI/LO.
- MULT/MULTU/DIV/DIVU in IDLE:
  - Latch the magnitudes of the operands (signed ops take absolute values; unsigned ops take them raw).
  - Latch the sign flags.
  - Go to CALC.
- Multiply is radix-2 shift-add: 64-bit product, with HI as the upper word and LO as the lower word.
- Divide is restoring, one quotient bit per iteration: LO is the quotient, HI is the remainder.
- FIX handles signs:
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: the quotient is negative if the signs differ; the remainder takes the dividend's sign.
- Divide by zero, signed or unsigned: normal latency, LO=32'hFFFF_FFFF, HI=a_i32.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- Any MDU funct while busy is ignored; stall_o=1 and the upstream holds the instruction.
- MFHI/MFLO while busy also stall and return the old value; the pipeline must not consume it.

## Timing
- Reset values:
  - State IDLE, HI=0, LO=0.
  - busy_o=0, done_o=0, illegal_o=0.
  - y_o32=0, stall_o=0 (for any start_i not MFHI/MFLO).
- Start sampled at edge 0. busy_o is high in cycles 1 through 33 (32 CALC plus 1 FIX).
- HI/LO are written at edge 34. State returns to IDLE, and done_o=1 during cycle 34 only.
- A new MULT/DIV may be accepted in cycle 34, so back-to-back throughput is 34 cycles.
- MTHI/MTLO latency is 1 cycle. MFHI/MFLO latency is 0 cycles.
- reset_n_i low in any state aborts the operation: IDLE, HI=LO=0, and no done_o pulse.
- Simultaneous FIX write and start in cycle 33: start is stalled, because busy_o is still 1.

## Configuration
- MDU_DIV_EN defined:
  - DIV/DIVU are implemented as above.
  - illegal_o is constant 0.
- MDU_DIV_EN undefined:
  - No divider datapath.
  - DIV/DIVU accepted in IDLE pulse illegal_o for one cycle, leave HI/LO unchanged, and never assert busy_o.
  - MULT/MULTU/MF/MT behaviour is unchanged.

## Test plan
- MULT a=32'hFFFF_FFFE (-2), b=3 -> done_o in cycle 34, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. MULTU with the same operands -> HI=2, LO=32'hFFFF_FFFA.
- DIV a=-7, b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIVU a=7, b=0 -> LO=32'hFFFF_FFFF, HI=7.
- MFLO issued in cycle 5 of a MULT -> stall_o=1 through cycle 33. MFLO in cycle 34 -> y_o32 equals the new LO.
- MTHI 32'h1234_5678, then MFHI the next cycle -> y_o32=32'h1234_5678. MTLO while busy -> LO unchanged and stall_o=1.
- reset_n_i low in cycle 20 of a DIV -> next cycle busy_o=0, HI=LO=0, and no done_o pulse follows.
- Build without MDU_DIV_EN: DIVU 8/2 -> illegal_o pulses one cycle, busy_o stays 0, HI/LO are unchanged. Build with it: illegal_o is never asserted.

Source files
------------

// File: rtl/mdu.sv
// mdu - iterative multiply/divide unit beside the execute-stage ALU.
// Holds the architectural HI/LO registers. MULT/MULTU use a radix-2 shift-add
// multiplier and DIV/DIVU a restoring divider. Each takes 32 iterations plus
// one sign-fix cycle. MFHI/MFLO read data is combinational.
//
// Optional feature: define MDU_DIV_EN to build the divider. Without it, an
// accepted DIV/DIVU only pulses illegal_o and leaves HI/LO unchanged.
//
// Ports:
//   clk_i      core clock
//   reset_n_i  synchronous active-low reset
//   start_i    instruction valid this cycle
//   funct_i6   R-type funct field
//   a_i32      rs operand
//   b_i32      rt operand
//   y_o32      HI on MFHI, LO on MFLO, otherwise 0
//   busy_o     MULT/DIV in flight
//   stall_o    MDU instruction presented while busy
//   done_o     one-cycle pulse when HI/LO take a MULT/DIV result
//   illegal_o  one-cycle pulse for an accepted DIV/DIVU when no divider is built
//
// state | meaning
// IDLE  | accepts instructions
// CALC  | one multiply/divide iteration per cycle, cnt_q runs 31 to 0
// FIX   | sign correction and HI/LO write
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i6,
  input  logic [WIDTH-1:0] a_i32,
  input  logic [WIDTH-1:0] b_i32,
  output logic [WIDTH-1:0] y_o32,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             illegal_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] p_q, p_d;      // {partial HI / remainder, multiplier / dividend -> quotient}
  logic [WIDTH-1:0]   m_q, m_d;      // multiplicand or divisor magnitude
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic is_mult, is_div, is_mdu, is_signed, accept_op;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mult   = (funct_i6 == F_MULT) || (funct_i6 == F_MULTU);
  assign is_div    = (funct_i6 == F_DIV)  || (funct_i6 == F_DIVU);
  assign is_mdu    = is_mult || is_div || (funct_i6 == F_MFHI) || (funct_i6 == F_MTHI) ||
                     (funct_i6 == F_MFLO) || (funct_i6 == F_MTLO);
  assign is_signed = ~funct_i6[0];
  assign a_mag     = (is_signed && a_i32[WIDTH-1]) ? -a_i32 : a_i32;
  assign b_mag     = (is_signed && b_i32[WIDTH-1]) ? -b_i32 : b_i32;

  assign busy_o  = (state_q != S_IDLE);
  assign stall_o = start_i && is_mdu && busy_o;
  assign done_o  = done_q;
  assign y_o32   = (start_i && funct_i6 == F_MFHI) ? hi_q :
                   (start_i && funct_i6 == F_MFLO) ? lo_q : '0;

  // Shift-add: conditionally add multiplicand into the upper half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  // Restoring divide: shift in the next dividend bit, subtract when it fits.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = |a|.
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;
  assign div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, m_q};
  assign div_rem  = div_sh[WIDTH-1:0] - m_q;
  assign div_step = div_ge ? {div_rem, p_q[WIDTH-2:0], 1'b1}
                           : {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
  assign accept_op = is_mult || is_div;
  assign illegal_o = 1'b0;
`else
  logic illegal_q;
  assign accept_op = is_mult;
  assign illegal_o = illegal_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) illegal_q <= 1'b0;
    else            illegal_q <= (state_q == S_IDLE) && start_i && is_div;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    p_d       = p_q;
    m_d       = m_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (funct_i6 == F_MTHI) hi_d = a_i32;
          if (funct_i6 == F_MTLO) lo_d = a_i32;
          if (accept_op) begin
            state_d   = S_CALC;
            cnt_d     = CW'(WIDTH-1);
            p_d       = {{WIDTH{1'b0}}, a_mag};
            m_d       = b_mag;
            div_d     = is_div;
            neg_res_d = is_signed && (a_i32[WIDTH-1] ^ b_i32[WIDTH-1]);
            neg_rem_d = is_signed && is_div && a_i32[WIDTH-1];
            dz_d      = is_div && (b_i32 == '0);
          end
        end
      end
      S_CALC: begin
`ifdef MDU_DIV_EN
        p_d = div_q ? div_step : mul_step;
`else
        p_d = mul_step;
`endif
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = neg_res_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
          if (dz_q) lo_d = '1;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -p_q : p_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      p_q       <= '0;
      m_q       <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      p_q       <= p_d;
      m_q       <= m_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [5:0]  funct_i6;
  logic [31:0] a_i32, b_i32, y_o32;
  logic        busy_o, stall_o, done_o, illegal_o;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ill_cnt = 0;

  mdu #(.WIDTH(32)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .funct_i6(funct_i6),
    .a_i32(a_i32), .b_i32(b_i32), .y_o32(y_o32), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (illegal_o) ill_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; funct_i6 = f; a_i32 = a; b_i32 = b;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    start_i = 1'b1; funct_i6 = F_MFHI; #1; hi = y_o32;
    funct_i6 = F_MFLO; #1; lo = y_o32;
    start_i = 1'b0; funct_i6 = 6'h00;
  endtask

  // Issue a MULT/DIV, wait (bounded) for done_o, return latency and HI/LO.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo);
    issue(f, a, b);
    tick();
    lat = 1;
    start_i = 1'b0;
    while (done_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    read_hilo(hi, lo);
  endtask

  initial begin
    int lat;
    int bad;
    logic [31:0] hi, lo;
    logic [5:0]  abort_f;

    reset_n_i = 1'b0; start_i = 1'b0; funct_i6 = 6'h00; a_i32 = '0; b_i32 = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_illegal", {31'd0, illegal_o}, 32'd0);
    reset_n_i = 1'b1;
    tick();
    issue(F_MULT, 32'd5, 32'd6); #1;
    check("idle_stall", {31'd0, stall_o}, 32'd0);
    start_i = 1'b0;
    read_hilo(hi, lo);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // MULT -2*3 with MFLO held from cycle 5 through the end
    issue(F_MULT, 32'hFFFF_FFFE, 32'd3);
    tick();
    start_i = 1'b0;
    check("mult_busy_c1", {31'd0, busy_o}, 32'd1);
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) begin start_i = 1'b1; funct_i6 = F_MFLO; end
      #1;
      if (c >= 5 && (stall_o !== 1'b1 || y_o32 !== 32'h0)) bad++;
      if (c < 33) tick();
    end
    check("mflo_stall_cycles", bad, 0);
    check("mult_busy_c33", {31'd0, busy_o}, 32'd1);
    check("mult_done_c33", {31'd0, done_o}, 32'd0);
    tick();
    check("mult_done_c34", {31'd0, done_o}, 32'd1);
    check("mult_busy_c34", {31'd0, busy_o}, 32'd0);
    check("mult_stall_c34", {31'd0, stall_o}, 32'd0);
    check("mult_lo", y_o32, 32'hFFFF_FFFA);
    funct_i6 = F_MFHI; #1;
    check("mult_hi", y_o32, 32'hFFFF_FFFF);
    start_i = 1'b0;
    tick();
    check("done_one_cycle", {31'd0, done_o}, 32'd0);

    run_op(F_MULTU, 32'hFFFF_FFFE, 32'd3, lat, hi, lo);
    check("multu_lat", lat, 34);
    check("multu_hi", hi, 32'h2);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, lat, hi, lo);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0);
    run_op(F_MULT, 32'd7, 32'hFFFF_FFFB, lat, hi, lo);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFDD);

    // MTHI then MFHI next cycle; MTLO while busy is ignored
    issue(F_MTHI, 32'h1234_5678, 32'h0);
    tick();
    start_i = 1'b1; funct_i6 = F_MFHI; #1;
    check("mthi_mfhi", y_o32, 32'h1234_5678);
    funct_i6 = F_MTLO; a_i32 = 32'hAAAA_5555;
    tick();
    issue(F_MULTU, 32'd3, 32'd4);
    tick();
    issue(F_MTLO, 32'hDEAD_BEEF, 32'h0); #1;
    check("mtlo_busy_stall", {31'd0, stall_o}, 32'd1);
    tick();
    funct_i6 = F_MFLO; #1;
    check("mtlo_busy_lo", y_o32, 32'hAAAA_5555);
    start_i = 1'b0;
    lat = 2;
    while (done_o !== 1'b1 && lat < 40) begin tick(); lat++; end
    check("mtlo_busy_lat", lat, 34);
    read_hilo(hi, lo);
    check("multu_small_lo", lo, 32'd12);
    check("multu_small_hi", hi, 32'd0);

`ifdef MDU_DIV_EN
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, hi, lo);
    check("div_lat", lat, 34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(F_DIVU, 32'd7, 32'd0, lat, hi, lo);
    check("divu0_lat", lat, 34);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd0, lat, hi, lo);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFF9);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);
    run_op(F_DIVU, 32'd100, 32'd7, lat, hi, lo);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    abort_f = F_DIV;
`else
    issue(F_MTHI, 32'h11, 32'h0); tick();
    issue(F_MTLO, 32'h22, 32'h0); tick();
    issue(F_DIVU, 32'd8, 32'd2);
    tick();
    start_i = 1'b0;
    check("ill_pulse", {31'd0, illegal_o}, 32'd1);
    check("ill_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check("ill_one_cycle", {31'd0, illegal_o}, 32'd0);
    check("ill_busy2", {31'd0, busy_o}, 32'd0);
    read_hilo(hi, lo);
    check("ill_hi", hi, 32'h11);
    check("ill_lo", lo, 32'h22);
    abort_f = F_MULT;
`endif

    // reset in cycle 20 of an operation aborts it
    issue(abort_f, 32'd100, 32'd7);
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("abort_busy_c20", {31'd0, busy_o}, 32'd1);
    reset_n_i = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    reset_n_i = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) tick();
    check("abort_no_done", done_cnt, 0);
    read_hilo(hi, lo);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);

`ifdef MDU_DIV_EN
    check("illegal_never", ill_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
